mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller: byte/half/word loads and stores,
// sub-word stores done as read-modify-write, with alignment and range checks.
module mem_access_ctrl #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req_err;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_d;
    logic [31:0] merge_d;

    assign req_err = (req_size == SZ_X)
                   | ((req_size == SZ_H) & req_addr[0])
                   | ((req_size == SZ_W) & (|req_addr[1:0]))
                   | ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

    always_comb begin
        lane_b = 8'h00;
        unique case (addr_q[1:0])
            2'd0: lane_b = mem_rdata[7:0];
            2'd1: lane_b = mem_rdata[15:8];
            2'd2: lane_b = mem_rdata[23:16];
            2'd3: lane_b = mem_rdata[31:24];
        endcase
        lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_d = mem_rdata;
        if (size_q == SZ_B)
            load_d = {{24{signed_q & lane_b[7]}}, lane_b};
        else if (size_q == SZ_H)
            load_d = {{16{signed_q & lane_h[15]}}, lane_h};

        // Store data is right-justified; only the addressed lanes change.
        merge_d = mem_rdata;
        if (size_q == SZ_B)
            merge_d[{addr_q[1:0], 3'b000} +: 8] = mem_wdata_q[7:0];
        else
            merge_d[{addr_q[1], 4'b0000} +: 16] = mem_wdata_q[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            size_q      <= SZ_B;
            signed_q    <= 1'b0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        size_q      <= req_size;
                        signed_q    <= req_signed;
                        mem_wdata_q <= req_wdata;
                        if (req_err) begin
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else if (!req_we) begin
                            state_q <= LOAD;
                        end else if (req_size == SZ_W) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    rdata_q <= load_d;
                    state_q <= RESP;
                end
                RMW_RD: begin
                    mem_wdata_q <= merge_d;
                    state_q     <= WRITE;
                end
                WRITE: begin
                    state_q <= RESP;
                end
                RESP: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_we     = (state_q == WRITE);
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: reference memory model with a per-cycle
// compare process plus literal checks of each directed transaction.
module tb_mem_access_ctrl;

    localparam int MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_access_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT
    logic [31:0] mem [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    bit preload = 1'b1;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM_WORDS; i++)
                mem[i] <= 32'h01010101 * 32'(i);
            mem[4] <= 32'h8899AABB;
            mem[5] <= 32'h11223344;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    int          exp_acc = -10;
    int          exp_resp_at = -10;
    int          exp_we_at = -10;
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_wdata = '0;
    logic [31:0] exp_waddr = '0;

    int          rlog_cyc[$];
    logic [31:0] rlog_data[$];
    logic        rlog_err[$];
    int          wlog_cyc[$];
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: outcome of one accepted request in cycle n
    task automatic model_issue(input int n, input logic we, input logic [1:0] sz,
                               input logic sg, input logic [31:0] a,
                               input logic [31:0] wd);
        int idx;
        int sh;
        logic [31:0] v;
        logic [31:0] mask;
        logic err;
        idx = int'(a >> 2);
        sh = 8 * int'(a & 32'h3);
        err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0)
           || (sz == 2'd2 && (a % 4) != 0) || ((a >> 2) >= 32'(MEM_WORDS));
        exp_acc = n;
        exp_we_at = -10;
        exp_err = 1'b0;
        exp_rdata = '0;
        if (err) begin
            exp_err = 1'b1;
            exp_resp_at = n + 1;
        end else if (!we) begin
            v = ref_mem[idx] >> sh;
            if (sz == 2'd0) begin
                v = v & 32'hFF;
                if (sg && v >= 32'h80) v = v - 32'h100;
            end else if (sz == 2'd1) begin
                v = v & 32'hFFFF;
                if (sg && v >= 32'h8000) v = v - 32'h10000;
            end
            exp_rdata = v;
            exp_resp_at = n + 2;
        end else begin
            exp_waddr = a & ~32'h3;
            if (sz == 2'd2) begin
                exp_wdata = wd;
                exp_we_at = n + 1;
                exp_resp_at = n + 2;
            end else begin
                mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
                exp_wdata = (ref_mem[idx] & ~mask) | ((wd << sh) & mask);
                exp_we_at = n + 2;
                exp_resp_at = n + 3;
            end
            ref_mem[idx] = exp_wdata;
        end
    endtask

    // Every cycle: outputs must match the model
    always @(negedge clk) begin
        if (checking) begin
            chk1("req_ready", req_ready, (cyc <= exp_acc) || (cyc > exp_resp_at));
            chk1("resp_valid", resp_valid, cyc == exp_resp_at);
            chk1("mem_we", mem_we, cyc == exp_we_at);
            if (cyc == exp_resp_at) begin
                chk32("resp_rdata", resp_rdata, exp_rdata);
                chk1("resp_err", resp_err, exp_err);
            end else begin
                chk32("idle_rdata", resp_rdata, 32'h0);
                chk1("idle_err", resp_err, 1'b0);
            end
            if (cyc == exp_we_at) begin
                chk32("mem_wdata", mem_wdata, exp_wdata);
                chk32("mem_addr", mem_addr, exp_waddr);
            end
            if (resp_valid) begin
                rlog_cyc.push_back(cyc);
                rlog_data.push_back(resp_rdata);
                rlog_err.push_back(resp_err);
            end
            if (mem_we) begin
                wlog_cyc.push_back(cyc);
                wlog_addr.push_back(mem_addr);
                wlog_data.push_back(mem_wdata);
            end
        end
    end

    // Called at posedge+1; drives and holds the request until accepted
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int n);
        req_valid = 1'b1;
        req_we = we;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = wd;
        for (int k = 0; k < 20 && cyc <= exp_resp_at; k++) begin
            @(posedge clk);
            #1;
        end
        n = cyc;
        model_issue(n, we, sz, sg, a, wd);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && cyc <= exp_resp_at; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_resp(input string nm, input int n, input int lat,
                               input logic [31:0] rd, input logic er);
        if (rlog_cyc.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: no response seen, want one at latency %0d", nm, lat);
        end else begin
            int c;
            logic [31:0] d;
            logic e;
            c = rlog_cyc.pop_front();
            d = rlog_data.pop_front();
            e = rlog_err.pop_front();
            chk32({nm, "_lat"}, 32'(c - n), 32'(lat));
            chk32({nm, "_rdata"}, d, rd);
            chk1({nm, "_err"}, e, er);
        end
    endtask

    task automatic expect_we(input string nm, input int n, input int lat,
                             input logic [31:0] wa, input logic [31:0] wd);
        if (wlog_cyc.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: no mem_we pulse seen, want one at latency %0d", nm, lat);
        end else begin
            int c;
            logic [31:0] a;
            logic [31:0] d;
            c = wlog_cyc.pop_front();
            a = wlog_addr.pop_front();
            d = wlog_data.pop_front();
            chk32({nm, "_we_lat"}, 32'(c - n), 32'(lat));
            chk32({nm, "_we_addr"}, a, wa);
            chk32({nm, "_we_data"}, d, wd);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, n2, n3, n4;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_signed = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < MEM_WORDS; i++)
            ref_mem[i] = 32'h01010101 * 32'(i);
        ref_mem[4] = 32'h8899AABB;
        ref_mem[5] = 32'h11223344;

        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        checking = 1'b1;
        chk1("rst_ready", req_ready, 1'b1);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk32("rst_rdata", resp_rdata, 32'h0);
        chk1("rst_err", resp_err, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);

        // Accepted on the first edge after reset release
        rst = 1'b0;
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, n1);
        drain();
        expect_resp("lb_s_11", n1, 2, 32'hFFFFFFAA, 1'b0);

        // Second request is held while the first is in flight
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, n1);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, n2);
        drain();
        expect_resp("lh_u_12", n1, 2, 32'h00008899, 1'b0);
        expect_resp("lh_s_12", n2, 2, 32'hFFFF8899, 1'b0);
        chk32("held_accept_gap", 32'(n2 - n1), 32'd3);

        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h1234565A, n1);
        drain();
        expect_we("sb_13", n1, 2, 32'h10, 32'h5A99AABB);
        expect_resp("sb_13", n1, 3, 32'h0, 1'b0);

        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, n1);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, n2);
        drain();
        expect_we("sw_20", n1, 1, 32'h20, 32'hDEADBEEF);
        expect_resp("sw_20", n1, 2, 32'h0, 1'b0);
        expect_resp("lw_20", n2, 2, 32'hDEADBEEF, 1'b0);

        do_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, n1);
        do_req(1'b1, 2'b01, 1'b0, 32'h01, 32'hFFFF, n2);
        do_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, n3);
        do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, n4);
        drain();
        expect_resp("err_lw_22", n1, 1, 32'h0, 1'b1);
        expect_resp("err_sh_01", n2, 1, 32'h0, 1'b1);
        expect_resp("err_size3", n3, 1, 32'h0, 1'b1);
        expect_resp("err_lw_400", n4, 1, 32'h0, 1'b1);

        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, n1);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, n2);
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hABCDCAFE, n3);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, n4);
        drain();
        expect_resp("lbu_10", n1, 2, 32'h000000BB, 1'b0);
        expect_resp("lb_s_13", n2, 2, 32'h0000005A, 1'b0);
        expect_we("sh_12", n3, 2, 32'h10, 32'hCAFEAABB);
        expect_resp("sh_12", n3, 3, 32'h0, 1'b0);
        expect_resp("lw_10", n4, 2, 32'hCAFEAABB, 1'b0);

        do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, n1);
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, n2);
        drain();
        expect_resp("lw_3fc", n1, 2, 32'hFFFFFFFF, 1'b0);
        expect_resp("lh_s_10", n2, 2, 32'hFFFFAABB, 1'b0);

        // Reset while the byte store sits in its write cycle
        do_req(1'b1, 2'b00, 1'b0, 32'h15, 32'h77, n1);
        @(posedge clk);
        #1;
        chk1("wr_we_before_rst", mem_we, 1'b1);
        chk32("wr_data_before_rst", mem_wdata, 32'h11227744);
        #1;
        rst = 1'b1;
        exp_acc = -10;
        exp_resp_at = -10;
        exp_we_at = -10;
        #1;
        chk1("rst_mid_we", mem_we, 1'b0);
        chk1("rst_mid_ready", req_ready, 1'b1);
        chk1("rst_mid_resp", resp_valid, 1'b0);
        chk32("rst_mid_addr", mem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk32("rst_mem_unchanged", mem[5], 32'h11223344);
        ref_mem[5] = 32'h11223344;
        rst = 1'b0;
        do_req(1'b0, 2'b00, 1'b0, 32'h15, 32'h0, n1);
        drain();
        expect_resp("lbu_15_after_rst", n1, 2, 32'h00000033, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk32("stray_resp", 32'(rlog_cyc.size()), 32'd0);
        chk32("stray_we", 32'(wlog_cyc.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
